// File: rtl/mcb_cmd_seq.sv
// Command sequencer for the sdrc_lite SDR SDRAM back-end: turns one access or refresh
// request at a time into the address-latch pulse and single-cycle command strobes.
module mcb_cmd_seq #(
    parameter int MCB_B_W = 2,
    parameter int MCB_R_W = 13,
    parameter int MCB_C_W = 9,
    parameter int LEN_W   = 4,
    parameter int BL      = 4,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int T_WR    = 2,
    parameter int T_RFC   = 7
) (
    input  logic               mcb_clk,
    input  logic               mcb_rst_n,
    input  logic               mcb_sclr_n,
    input  logic               init_done,
    input  logic               ref_req,
    output logic               ref_ack,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [MCB_B_W-1:0] req_ba,
    input  logic [MCB_R_W-1:0] req_ra,
    input  logic [MCB_C_W-1:0] req_ca,
    input  logic [LEN_W-1:0]   req_len,
    output logic               mcb_bb,
    output logic [MCB_B_W-1:0] mcb_ba,
    output logic [MCB_R_W-1:0] mcb_ra,
    output logic [MCB_C_W-1:0] mcb_ca,
    output logic               c_act,
    output logic               c_rd,
    output logic               c_rda,
    output logic               c_wr,
    output logic               c_wra,
    output logic               c_ref,
    output logic               busy,
    output logic               xfer_done,
    output logic [3:0]         state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_ACT, S_RCD, S_COL, S_GAP, S_RECOV, S_REF, S_RFC
    } state_t;

    localparam int CNT_W = 8;
    // Wait counters are loaded with (duration - 2): the entry cycle is the state itself.
    localparam logic [CNT_W-1:0] RFC_LD    = CNT_W'(T_RFC - 2);
    localparam logic [CNT_W-1:0] RCD_LD    = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(BL - 2);
    localparam logic [CNT_W-1:0] RD_REC_LD = CNT_W'(BL + T_RP - 2);
    localparam logic [CNT_W-1:0] WR_REC_LD = CNT_W'(BL + T_WR + T_RP - 2);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [LEN_W-1:0]   burst_left, burst_d;
    logic               rw_q;
    logic [MCB_C_W-1:0] ca_next;
    logic               accept;
    logic               final_burst;

    assign final_burst = (burst_left == '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        burst_d = burst_left;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done && ref_req) begin
                    state_d = S_REF;
                end else if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = S_LATCH;
                    burst_d = req_len;
                end
            end
            S_REF: begin
                if (T_RFC == 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RFC;
                    cnt_d   = RFC_LD;
                end
            end
            S_RFC: begin
                if (cnt == '0) state_d = S_IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_LATCH: state_d = S_ACT;
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_d = S_COL;
                end else begin
                    state_d = S_RCD;
                    cnt_d   = RCD_LD;
                end
            end
            S_RCD, S_GAP: begin
                if (cnt == '0) state_d = S_COL;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_COL: begin
                if (final_burst) begin
                    state_d = S_RECOV;
                    cnt_d   = rw_q ? WR_REC_LD : RD_REC_LD;
                end else begin
                    burst_d = burst_left - LEN_W'(1);
                    if (BL == 1) begin
                        state_d = S_COL;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end
                end
            end
            S_RECOV: begin
                if (cnt == '0) state_d = S_IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            burst_left <= '0;
            rw_q       <= 1'b0;
            mcb_ba     <= '0;
            mcb_ra     <= '0;
            mcb_ca     <= '0;
            ca_next    <= '0;
        end else if (!mcb_sclr_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            burst_left <= '0;
            rw_q       <= 1'b0;
            mcb_ba     <= '0;
            mcb_ra     <= '0;
            mcb_ca     <= '0;
            ca_next    <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            burst_left <= burst_d;
            if (accept) begin
                rw_q    <= req_rw;
                mcb_ba  <= req_ba;
                mcb_ra  <= req_ra;
                mcb_ca  <= req_ca;
                ca_next <= req_ca;
            end else if (state_d == S_COL) begin
                // Column address changes only as the strobe appears; wraps modulo 2^MCB_C_W.
                mcb_ca  <= ca_next;
                ca_next <= ca_next + MCB_C_W'(BL);
            end
        end
    end

    // Handshake: a request transfers on a cycle where req_valid && req_ready; the request
    // fields must be stable while req_valid is high and are registered on that edge.
    assign req_ready = mcb_rst_n && (state == S_IDLE) && init_done && !ref_req;

    assign mcb_bb    = (state == S_LATCH);
    assign c_act     = (state == S_ACT);
    assign c_rd      = (state == S_COL) && !final_burst && !rw_q;
    assign c_wr      = (state == S_COL) && !final_burst &&  rw_q;
    assign c_rda     = (state == S_COL) &&  final_burst && !rw_q;
    assign c_wra     = (state == S_COL) &&  final_burst &&  rw_q;
    assign c_ref     = (state == S_REF);
    assign ref_ack   = c_ref;
    assign busy      = (state != S_IDLE);
    assign xfer_done = (state == S_RECOV) && (cnt == '0);
    assign state_dbg = state;

endmodule

// File: tb/tb_mcb_cmd_seq.sv
// Bench for mcb_cmd_seq: directed vector table, multi-cycle corner sequences, and a
// randomized run checked cycle by cycle against a timing-schedule reference model.
module tb_mcb_cmd_seq;

    localparam int B_W   = 2;
    localparam int R_W   = 13;
    localparam int C_W   = 9;
    localparam int LEN_W = 4;
    localparam int BL    = 4;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_WR  = 2;
    localparam int T_RFC = 7;
    localparam int R_RD  = BL + T_RP;
    localparam int R_WR  = BL + T_WR + T_RP;
    localparam int NS    = 2200;

    localparam logic [5:0] K_ACT = 6'b100000;
    localparam logic [5:0] K_RD  = 6'b010000;
    localparam logic [5:0] K_RDA = 6'b001000;
    localparam logic [5:0] K_WR  = 6'b000100;
    localparam logic [5:0] K_WRA = 6'b000010;
    localparam logic [5:0] K_REF = 6'b000001;

    localparam int OBS_W = 1 + 6 + 4 + B_W + R_W + C_W;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sclr_n = 1'b1;
    logic             init_done = 1'b1;
    logic             ref_req = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_rw = 1'b0;
    logic [B_W-1:0]   req_ba = '0;
    logic [R_W-1:0]   req_ra = '0;
    logic [C_W-1:0]   req_ca = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             ref_ack, req_ready, mcb_bb, busy, xfer_done;
    logic [B_W-1:0]   mcb_ba;
    logic [R_W-1:0]   mcb_ra;
    logic [C_W-1:0]   mcb_ca;
    logic             c_act, c_rd, c_rda, c_wr, c_wra, c_ref;
    logic [3:0]       state_dbg;

    always #5 clk = ~clk;

    mcb_cmd_seq dut (
        .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_n),
        .init_done(init_done), .ref_req(ref_req), .ref_ack(ref_ack),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_ba(req_ba), .req_ra(req_ra), .req_ca(req_ca), .req_len(req_len),
        .mcb_bb(mcb_bb), .mcb_ba(mcb_ba), .mcb_ra(mcb_ra), .mcb_ca(mcb_ca),
        .c_act(c_act), .c_rd(c_rd), .c_rda(c_rda), .c_wr(c_wr), .c_wra(c_wra), .c_ref(c_ref),
        .busy(busy), .xfer_done(xfer_done), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [OBS_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] cmds();
        return {c_act, c_rd, c_rda, c_wr, c_wra, c_ref};
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return {mcb_bb, cmds(), ref_ack, busy, req_ready, xfer_done, mcb_ba, mcb_ra, mcb_ca};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle_timeout"}, ok, 1);
        tick();
    endtask

    task automatic drive_req(input logic rw, input logic [B_W-1:0] ba, input logic [R_W-1:0] ra,
                             input logic [C_W-1:0] ca, input logic [LEN_W-1:0] len);
        req_valid = 1'b1;
        req_rw    = rw;
        req_ba    = ba;
        req_ra    = ra;
        req_ca    = ca;
        req_len   = len;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rw;
        logic [B_W-1:0]   ba;
        logic [R_W-1:0]   ra;
        logic [C_W-1:0]   ca;
        logic [LEN_W-1:0] len;
        int               bb_c;
        int               act_c;
        int               c0_c;
        logic [C_W-1:0]   c0_ca;
        logic [5:0]       c0_cmd;
        int               last_c;
        logic [C_W-1:0]   last_ca;
        logic [5:0]       last_cmd;
        int               ncol;
        int               done_c;
        int               rdy_c;
    } vec_t;

    vec_t vt[5];

    function automatic vec_t mk_vec(input logic rw, input int ba, input int ra, input int ca,
                                    input int len, input int bb_c, input int act_c,
                                    input int c0_c, input int c0_ca, input logic [5:0] c0_cmd,
                                    input int last_c, input int last_ca, input logic [5:0] last_cmd,
                                    input int ncol, input int done_c, input int rdy_c);
        vec_t v;
        v.rw = rw; v.ba = B_W'(ba); v.ra = R_W'(ra); v.ca = C_W'(ca); v.len = LEN_W'(len);
        v.bb_c = bb_c; v.act_c = act_c;
        v.c0_c = c0_c; v.c0_ca = C_W'(c0_ca); v.c0_cmd = c0_cmd;
        v.last_c = last_c; v.last_ca = C_W'(last_ca); v.last_cmd = last_cmd;
        v.ncol = ncol; v.done_c = done_c; v.rdy_c = rdy_c;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int bb_c, act_c, c0_c, last_c, done_c, rdy_c, ncol;
        logic [C_W-1:0] c0_ca, last_ca, bb_ca;
        logic [B_W-1:0] bb_ba;
        logic [R_W-1:0] bb_ra;
        logic [5:0] c0_cmd, last_cmd;
        logic rdy0;
        string p;
        bb_c = -1; act_c = -1; c0_c = -1; last_c = -1; done_c = -1; rdy_c = -1; ncol = 0;
        c0_ca = '0; last_ca = '0; bb_ca = '0; bb_ba = '0; bb_ra = '0;
        c0_cmd = '0; last_cmd = '0; rdy0 = 1'b0;
        p = $sformatf("vec%0d", idx);
        wait_idle(p);
        drive_req(v.rw, v.ba, v.ra, v.ca, v.len);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) rdy0 = req_ready;
            if (mcb_bb && bb_c < 0) begin
                bb_c = c; bb_ba = mcb_ba; bb_ra = mcb_ra; bb_ca = mcb_ca;
            end
            if (c_act && act_c < 0) act_c = c;
            if (c_rd || c_wr || c_rda || c_wra) begin
                ncol++;
                if (c0_c < 0) begin
                    c0_c = c; c0_ca = mcb_ca; c0_cmd = cmds();
                end
            end
            if (c_rda || c_wra) begin
                last_c = c; last_ca = mcb_ca; last_cmd = cmds();
            end
            if (xfer_done && done_c < 0) done_c = c;
            if (c > 0 && req_ready && rdy_c < 0) rdy_c = c;
            tick();
            req_valid = 1'b0;
            if (rdy_c >= 0) break;
        end
        check({p, "_ready_at_accept"}, rdy0, 1);
        check({p, "_bb_cycle"}, bb_c, v.bb_c);
        check({p, "_bb_addr"}, {bb_ba, bb_ra, bb_ca}, {v.ba, v.ra, v.ca});
        check({p, "_act_cycle"}, act_c, v.act_c);
        check({p, "_col0_cycle"}, c0_c, v.c0_c);
        check({p, "_col0_ca"}, c0_ca, v.c0_ca);
        check({p, "_col0_cmd"}, c0_cmd, v.c0_cmd);
        check({p, "_last_cycle"}, last_c, v.last_c);
        check({p, "_last_ca"}, last_ca, v.last_ca);
        check({p, "_last_cmd"}, last_cmd, v.last_cmd);
        check({p, "_ncol"}, ncol, v.ncol);
        check({p, "_done_cycle"}, done_c, v.done_c);
        check({p, "_ready_cycle"}, rdy_c, v.rdy_c);
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic seq_ref_race();
        int cref, ack, early, rdy_c, bb;
        logic acc;
        cref = -1; ack = -1; early = 0; rdy_c = -1; bb = -1;
        wait_idle("race");
        ref_req = 1'b1;
        drive_req(1'b0, 2'd1, 13'd33, 9'd64, 4'd0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c_ref && cref < 0) cref = c;
            if (ref_ack && ack < 0) ack = c;
            if (c <= 7 && req_ready) early++;
            if (req_ready && rdy_c < 0) rdy_c = c;
            if (mcb_bb && bb < 0) bb = c;
            acc = req_valid && req_ready;
            tick();
            if (ack >= 0) ref_req = 1'b0;
            if (acc) req_valid = 1'b0;
            if (bb >= 0) break;
        end
        ref_req = 1'b0;
        req_valid = 1'b0;
        check("race_cref_cycle", cref, 1);
        check("race_ack_cycle", ack, 1);
        check("race_ready_early", early, 0);
        check("race_ready_cycle", rdy_c, 8);
        check("race_bb_cycle", bb, 9);
    endtask

    task automatic seq_ref_mid();
        int cref, bb2;
        logic rdy10, acc;
        cref = -1; bb2 = -1; rdy10 = 1'b1;
        wait_idle("refmid");
        drive_req(1'b0, 2'd2, 13'd9, 9'd40, 4'd0);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (c_ref && cref < 0) cref = c;
            if (mcb_bb && c > 1 && bb2 < 0) bb2 = c;
            if (c == 10) rdy10 = req_ready;
            tick();
            if (acc) req_valid = 1'b0;
            if (c == 2) begin
                ref_req = 1'b1;
                drive_req(1'b1, 2'd3, 13'd10, 9'd100, 4'd0);
            end
            if (cref >= 0) ref_req = 1'b0;
            if (bb2 >= 0) break;
        end
        ref_req = 1'b0;
        req_valid = 1'b0;
        check("refmid_cref_cycle", cref, 11);
        check("refmid_ready_at_idle", rdy10, 0);
        check("refmid_bb2_cycle", bb2, 19);
    endtask

    task automatic seq_sclr();
        logic busy3, busy4, rdy4;
        int ncol, ndone;
        busy3 = 1'b0; busy4 = 1'b1; rdy4 = 1'b0; ncol = 0; ndone = 0;
        wait_idle("sclr");
        drive_req(1'b0, 2'd0, 13'd1, 9'd4, 4'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 3) busy3 = busy;
            if (c == 4) begin
                busy4 = busy;
                rdy4 = req_ready;
            end
            if (c_rd || c_rda || c_wr || c_wra) ncol++;
            if (xfer_done) ndone++;
            tick();
            req_valid = 1'b0;
            if (c == 2) sclr_n = 1'b0;
            if (c == 3) sclr_n = 1'b1;
        end
        check("sclr_busy_in_rcd", busy3, 1);
        check("sclr_busy_after", busy4, 0);
        check("sclr_ready_after", rdy4, 1);
        check("sclr_no_col", ncol, 0);
        check("sclr_no_done", ndone, 0);
    endtask

    task automatic seq_arst();
        logic busy4;
        busy4 = 1'b0;
        wait_idle("arst");
        drive_req(1'b1, 2'd1, 13'd77, 9'd12, 4'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 4) busy4 = busy;
            tick();
            req_valid = 1'b0;
        end
        check("arst_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        check("arst_outputs", obs(), 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic seq_init_low();
        wait_idle("initlow");
        init_done = 1'b0;
        ref_req = 1'b1;
        drive_req(1'b0, 2'd0, 13'd2, 9'd3, 4'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("initlow_c%0d", c),
                  {req_ready, busy, mcb_bb, cmds(), ref_ack, xfer_done}, 0);
            tick();
        end
        init_done = 1'b1;
        ref_req = 1'b0;
        req_valid = 1'b0;
    endtask

    // ---------------- randomized run with schedule model ----------------
    logic [5:0]     ev_cmd[NS];
    logic           ev_bb[NS];
    logic           ev_done[NS];
    logic           ev_cset[NS];
    logic [C_W-1:0] ev_ca[NS];
    logic [B_W-1:0] ev_ba[NS];
    logic [R_W-1:0] ev_ra[NS];

    task automatic run_random(input int ncyc);
        int free_at, t, last, rec, len;
        logic ref_pend, req_pend, idle, e_ready;
        logic r_rw;
        logic [B_W-1:0] r_ba, h_ba;
        logic [R_W-1:0] r_ra, h_ra;
        logic [C_W-1:0] r_ca, h_ca;
        logic [LEN_W-1:0] r_len;
        logic [OBS_W-1:0] got;
        for (int i = 0; i < NS; i++) begin
            ev_cmd[i] = '0; ev_bb[i] = 1'b0; ev_done[i] = 1'b0; ev_cset[i] = 1'b0;
            ev_ca[i] = '0; ev_ba[i] = '0; ev_ra[i] = '0;
        end
        free_at = 0; ref_pend = 1'b0; req_pend = 1'b0;
        r_rw = 1'b0; r_ba = '0; r_ra = '0; r_ca = '0; r_len = '0;
        h_ba = '0; h_ra = '0; h_ca = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0 && ev_cmd[c-1] == K_REF) ref_pend = 1'b0;
            if (!ref_pend && $urandom_range(0, 49) == 0) ref_pend = 1'b1;
            if (!req_pend && $urandom_range(0, 2) == 0) begin
                req_pend = 1'b1;
                r_rw = 1'($urandom_range(0, 1));
                r_ba = B_W'($urandom_range(0, 3));
                r_ra = R_W'($urandom_range(0, 8191));
                r_ca = C_W'($urandom_range(0, 511));
                r_len = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15))
                                                    : LEN_W'($urandom_range(0, 2));
            end
            init_done = ($urandom_range(0, 24) != 0);
            ref_req   = ref_pend;
            req_valid = req_pend;
            req_rw = r_rw; req_ba = r_ba; req_ra = r_ra; req_ca = r_ca; req_len = r_len;

            idle = (c >= free_at);
            e_ready = idle && init_done && !ref_req;
            if (idle && init_done && ref_req) begin
                ev_cmd[c+1] = K_REF;
                free_at = c + 1 + T_RFC;
            end else if (e_ready && req_valid) begin
                len = int'(r_len);
                ev_bb[c+1] = 1'b1;
                ev_ba[c+1] = r_ba; ev_ra[c+1] = r_ra; ev_ca[c+1] = r_ca;
                ev_cmd[c+2] = K_ACT;
                for (int k = 0; k <= len; k++) begin
                    t = c + 2 + T_RCD + k * BL;
                    if (k == len) ev_cmd[t] = r_rw ? K_WRA : K_RDA;
                    else          ev_cmd[t] = r_rw ? K_WR : K_RD;
                    ev_ca[t] = C_W'(int'(r_ca) + k * BL);
                    ev_cset[t] = 1'b1;
                end
                last = c + 2 + T_RCD + len * BL;
                rec = r_rw ? R_WR : R_RD;
                ev_done[last + rec - 1] = 1'b1;
                free_at = last + rec;
                req_pend = 1'b0;
            end
            if (ev_bb[c]) begin
                h_ba = ev_ba[c]; h_ra = ev_ra[c]; h_ca = ev_ca[c];
            end
            if (ev_cset[c]) h_ca = ev_ca[c];
            exp_q.push_back({ev_bb[c], ev_cmd[c], ev_cmd[c] == K_REF, !idle, e_ready, ev_done[c],
                             h_ba, h_ra, h_ca});
            @(negedge clk);
            got = obs();
            check($sformatf("rand_c%0d", c), got, exp_q.pop_front());
            tick();
        end
        req_valid = 1'b0;
        ref_req = 1'b0;
        init_done = 1'b1;
    endtask

    // ---------------- main ----------------
    initial begin
        vt[0] = mk_vec(1'b0, 0, 5,    8,   0,  1, 2, 4, 8,   K_RDA, 4,  8,  K_RDA, 1,  9,  10);
        vt[1] = mk_vec(1'b1, 1, 7,    12,  1,  1, 2, 4, 12,  K_WR,  8,  16, K_WRA, 2,  15, 16);
        vt[2] = mk_vec(1'b0, 2, 100,  508, 1,  1, 2, 4, 508, K_RD,  8,  0,  K_RDA, 2,  13, 14);
        vt[3] = mk_vec(1'b1, 3, 8191, 0,   3,  1, 2, 4, 0,   K_WR,  16, 12, K_WRA, 4,  23, 24);
        vt[4] = mk_vec(1'b0, 1, 4096, 500, 15, 1, 2, 4, 500, K_RD,  64, 48, K_RDA, 16, 69, 70);

        #7;
        check("reset_outputs", obs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

        seq_ref_race();
        seq_ref_mid();
        seq_sclr();
        seq_arst();
        seq_init_low();

        wait_idle("pre_rand");
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        run_random(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
